// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup from IF is combinational; resolution from EX raises
// flush/redirect combinationally and updates the tables on the clock edge.
// All table state lives in registers so the async reset can clear it.
module branch_predictor_btb #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_next_pc,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_next_pc,
  output logic              flush,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [PERF_W-1:0] perf_updates,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [CNT_BITS-1:0] CTR_ONE = CNT_BITS'(1'b1);
  localparam logic [CNT_BITS-1:0] CTR_MAX = {CNT_BITS{1'b1}};
  // Weakly taken: only the MSB set.
  localparam logic [CNT_BITS-1:0] CTR_WT  = CTR_ONE << (CNT_BITS - 1);
  // Weakly not-taken: one below weakly taken (reset value).
  localparam logic [CNT_BITS-1:0] CTR_WNT = CTR_WT - CTR_ONE;
  localparam logic [XLEN-1:0]     PC_STEP = XLEN'(3'd4);
  localparam logic [PERF_W-1:0]   PERF_ONE = PERF_W'(1'b1);

  // Saturating increment: holds at the maximum instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    if (c == CTR_MAX) begin
      return c;
    end else begin
      return c + CTR_ONE;
    end
  endfunction

  // Saturating decrement: holds at zero instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] c);
    if (c == {CNT_BITS{1'b0}}) begin
      return c;
    end else begin
      return c - CTR_ONE;
    end
  endfunction

  // Table storage
  logic                valid_r  [ENTRIES];
  logic [TAG_W-1:0]    tag_r    [ENTRIES];
  logic [XLEN-1:0]     target_r [ENTRIES];
  logic [CNT_BITS-1:0] ctr_r    [ENTRIES];
  logic                jump_r   [ENTRIES];

  logic [PERF_W-1:0]   perf_updates_r;
  logic [PERF_W-1:0]   perf_mispredicts_r;

  // Address split for both ports
  logic [IDX-1:0]   lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic [IDX-1:0]   up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic [XLEN-1:0]  correct_next_s;
  logic             flush_s;

  assign lk_idx_s = lookup_pc[IDX+1:2];
  assign lk_tag_s = lookup_pc[XLEN-1:IDX+2];
  assign up_idx_s = upd_pc[IDX+1:2];
  assign up_tag_s = upd_pc[XLEN-1:IDX+2];

  // IF-stage lookup: tables read before any same-cycle update (no bypass).
  always_comb begin
    lk_hit_s     = 1'b0;
    pred_taken   = 1'b0;
    pred_next_pc = lookup_pc + PC_STEP;
    lk_hit_s     = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    if (lk_hit_s && (jump_r[lk_idx_s] || ctr_r[lk_idx_s][CNT_BITS-1])) begin
      pred_taken   = 1'b1;
      pred_next_pc = target_r[lk_idx_s];
    end else begin
      pred_taken   = 1'b0;
      pred_next_pc = lookup_pc + PC_STEP;
    end
  end

  // EX-stage resolution: compare carried prediction against the real outcome.
  always_comb begin
    up_hit_s       = 1'b0;
    correct_next_s = upd_pc + PC_STEP;
    flush_s        = 1'b0;
    redirect_pc    = {XLEN{1'b0}};
    up_hit_s       = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
    if (upd_taken) begin
      correct_next_s = upd_target;
    end else begin
      correct_next_s = upd_pc + PC_STEP;
    end
    if (upd_valid) begin
      flush_s     = (upd_pred_taken != upd_taken) || (upd_pred_next_pc != correct_next_s);
      redirect_pc = correct_next_s;
    end else begin
      flush_s     = 1'b0;
      redirect_pc = {XLEN{1'b0}};
    end
  end

  assign flush = flush_s;

  // Table update: allocate/train on taken, decay on not-taken hits only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {XLEN{1'b0}};
        ctr_r[i]    <= CTR_WNT;
        jump_r[i]   <= 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        valid_r[up_idx_s]  <= 1'b1;
        tag_r[up_idx_s]    <= up_tag_s;
        target_r[up_idx_s] <= upd_target;
        jump_r[up_idx_s]   <= upd_is_jump;
        if (upd_is_jump) begin
          ctr_r[up_idx_s] <= CTR_MAX;
        end else if (up_hit_s) begin
          ctr_r[up_idx_s] <= sat_inc(ctr_r[up_idx_s]);
        end else begin
          ctr_r[up_idx_s] <= CTR_WT;
        end
      end else if (up_hit_s) begin
        ctr_r[up_idx_s] <= sat_dec(ctr_r[up_idx_s]);
      end
    end
  end

  // Free-running performance counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_updates_r     <= {PERF_W{1'b0}};
      perf_mispredicts_r <= {PERF_W{1'b0}};
    end else begin
      if (upd_valid) begin
        perf_updates_r <= perf_updates_r + PERF_ONE;
      end
      if (flush_s) begin
        perf_mispredicts_r <= perf_mispredicts_r + PERF_ONE;
      end
    end
  end

  assign perf_updates     = perf_updates_r;
  assign perf_mispredicts = perf_mispredicts_r;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb (ENTRIES=16, CNT_BITS=2).
// Expectations are queued when stimulus is applied and popped/compared
// once the DUT outputs have settled.
module tb_branch_predictor_btb;

  logic        clk;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_next_pc;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] perf_updates;
  logic [31:0] perf_mispredicts;

  int tests_run;
  int tests_failed;

  typedef enum int {S_PT, S_PNPC, S_FLUSH, S_REDIR, S_PU, S_PM} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  branch_predictor_btb #(
    .XLEN(32), .ENTRIES(16), .CNT_BITS(2), .PERF_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_pc(lookup_pc), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_next_pc(upd_pred_next_pc),
    .flush(flush), .redirect_pc(redirect_pc),
    .perf_updates(perf_updates), .perf_mispredicts(perf_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop every queued expectation and compare with the settled DUT output.
  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        S_PT:    obs = {31'd0, pred_taken};
        S_PNPC:  obs = pred_next_pc;
        S_FLUSH: obs = {31'd0, flush};
        S_REDIR: obs = redirect_pc;
        S_PU:    obs = perf_updates;
        default: obs = perf_mispredicts;
      endcase
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic j,
                         input logic t, input logic [31:0] tgt,
                         input logic ppt, input logic [31:0] pnx);
    upd_valid = v; upd_pc = pc; upd_is_jump = j; upd_taken = t;
    upd_target = tgt; upd_pred_taken = ppt; upd_pred_next_pc = pnx;
  endtask

  // Look up a PC and queue the predicted outcome.
  task automatic expect_lookup(input string tag, input logic [31:0] pc,
                               input logic pt, input logic [31:0] nx);
    lookup_pc = pc;
    #1;
    push({tag, "_pt"}, S_PT, {31'd0, pt});
    push({tag, "_nx"}, S_PNPC, nx);
    drain();
  endtask

  // One resolved update: check flush/redirect in-cycle, then clock it in.
  task automatic do_update(input string tag, input logic [31:0] pc, input logic j,
                           input logic t, input logic [31:0] tgt,
                           input logic ppt, input logic [31:0] pnx,
                           input logic exp_flush, input logic [31:0] exp_redir);
    set_upd(1'b1, pc, j, t, tgt, ppt, pnx);
    #1;
    push({tag, "_flush"}, S_FLUSH, {31'd0, exp_flush});
    push({tag, "_redir"}, S_REDIR, exp_redir);
    drain();
    @(posedge clk);
    #1;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic expect_perf(input string tag, input logic [31:0] pu, input logic [31:0] pm);
    push({tag, "_pu"}, S_PU, pu);
    push({tag, "_pm"}, S_PM, pm);
    drain();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    lookup_pc = 32'h0;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. reset state
    expect_lookup("rst_lk100", 32'h100, 1'b0, 32'h104);
    expect_perf("rst", 32'd0, 32'd0);
    #1;
    push("idle_flush", S_FLUSH, 32'd0);
    push("idle_redir", S_REDIR, 32'd0);
    drain();

    // 2. first taken branch allocates weakly taken
    do_update("u40_t", 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1, 32'h80);
    expect_lookup("lk40_a", 32'h40, 1'b1, 32'h80);
    expect_perf("p2", 32'd1, 32'd1);

    // 3. decay to zero, saturate, one taken only reaches 1
    do_update("u40_nt1", 32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h44);
    expect_lookup("lk40_b", 32'h40, 1'b0, 32'h44);
    do_update("u40_nt2", 32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 32'h44, 1'b0, 32'h44);
    do_update("u40_nt3", 32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 32'h44, 1'b0, 32'h44);
    do_update("u40_t2", 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1, 32'h80);
    expect_lookup("lk40_sat", 32'h40, 1'b0, 32'h44);
    expect_perf("p3", 32'd5, 32'd3);

    // 4. alias at index 0
    do_update("u40_t3", 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1, 32'h80);
    expect_lookup("lk40_c", 32'h40, 1'b1, 32'h80);
    expect_lookup("lk440_a", 32'h440, 1'b0, 32'h444);
    do_update("u440_t", 32'h440, 1'b0, 1'b1, 32'h500, 1'b0, 32'h444, 1'b1, 32'h500);
    expect_lookup("lk440_b", 32'h440, 1'b1, 32'h500);
    expect_lookup("lk40_d", 32'h40, 1'b0, 32'h44);
    do_update("u40_ntmiss", 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0, 32'h44);
    expect_lookup("lk440_c", 32'h440, 1'b1, 32'h500);
    expect_perf("p4", 32'd8, 32'd5);

    // 5. jump, same-cycle lookup sees old contents
    lookup_pc = 32'h20;
    set_upd(1'b1, 32'h20, 1'b1, 1'b1, 32'h200, 1'b0, 32'h24);
    #1;
    push("lk20_nobyp_pt", S_PT, 32'd0);
    push("lk20_nobyp_nx", S_PNPC, 32'h24);
    drain();
    do_update("u20_j", 32'h20, 1'b1, 1'b1, 32'h200, 1'b0, 32'h24, 1'b1, 32'h200);
    expect_lookup("lk20_a", 32'h20, 1'b1, 32'h200);
    do_update("u20_ok", 32'h20, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    expect_perf("p5", 32'd10, 32'd6);
    expect_lookup("lk_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // 6. async reset mid-cycle during an update
    set_upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h300, 1'b0, 32'h104);
    lookup_pc = 32'h20;
    #2 rst_n = 1'b0;
    #1;
    push("rst_mid_pt", S_PT, 32'd0);
    push("rst_mid_nx", S_PNPC, 32'h24);
    push("rst_mid_flush", S_FLUSH, 32'd1);
    push("rst_mid_redir", S_REDIR, 32'h300);
    drain();
    expect_perf("rst_mid", 32'd0, 32'd0);
    @(posedge clk);
    #1;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    expect_lookup("post_lk100", 32'h100, 1'b0, 32'h104);
    expect_lookup("post_lk20", 32'h20, 1'b0, 32'h24);
    expect_lookup("post_lk440", 32'h440, 1'b0, 32'h444);
    expect_perf("post", 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
